// File: rtl/res_arb_pkg.sv
// Shared constants and read-return pipeline entry for the result RAM arbiter.
package res_arb_pkg;

  localparam int RES_AW    = 14;
  localparam int RES_DW    = 8;
  localparam int RES_DEPTH = 16384;
  localparam int RES_IDW   = 3;

  typedef struct packed {
    logic               valid;
    logic [RES_IDW-1:0] id;
  } rd_pipe_t;

endpackage

// File: rtl/res_ram_arbiter_if.sv
// Requester-side bus of the result RAM arbiter.
// The lock vector exists only when RES_ARB_LOCK_EN is defined.
interface res_ram_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 14,
  parameter int DW   = 8
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
`ifdef RES_ARB_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

`ifdef RES_ARB_LOCK_EN
  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );
  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
`else
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
`endif

endinterface

// File: rtl/res_ram_arbiter_rr_pick.sv
// Combinational one-hot round-robin picker.
// Priority starts at last+1 and wraps to index 0.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt
);

  logic [NREQ-1:0] g_hi;
  logic [NREQ-1:0] g_lo;
  logic            f_hi;
  logic            f_lo;

  // Lowest requester above last wins, else lowest overall.
  always_comb begin
    g_hi = '0;
    g_lo = '0;
    f_hi = 1'b0;
    f_lo = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (IW'(i) > last) && !f_hi) begin
        g_hi[i] = 1'b1;
        f_hi    = 1'b1;
      end
      if (req[i] && !f_lo) begin
        g_lo[i] = 1'b1;
        f_lo    = 1'b1;
      end
    end
    gnt = f_hi ? g_hi : g_lo;
  end

endmodule

// File: rtl/res_ram_arbiter.sv
// Round-robin arbiter sharing the single-port result RAM.
// Define RES_ARB_LOCK_EN to enable burst lock by the last winner.
module res_ram_arbiter
  import res_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RES_AW,
  parameter int DW   = RES_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  res_ram_arbiter_if.slave       bus,
  output logic                   res_rd,
  output logic                   res_wr,
  output logic [AW-1:0]          res_addr,
  output logic [DW-1:0]          res_do,
  input  logic [DW-1:0]          res_di
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic [IW-1:0]   win;
  logic            w_sel;
  logic [AW-1:0]   a_sel;
  logic [DW-1:0]   d_sel;

  logic [IW-1:0]   last_q, last_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   do_q, do_d;
  rd_pipe_t        pipe_q [2];
  rd_pipe_t        pipe_d [2];
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  always_comb begin
    elig = bus.req;
`ifdef RES_ARB_LOCK_EN
    for (int i = 0; i < NREQ; i++) begin
      if ((IW'(i) == last_q) && bus.lock[i] && bus.req[i]) begin
        elig    = '0;
        elig[i] = 1'b1;
      end
    end
`endif
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req  (elig),
    .last (last_q),
    .gnt  (pick)
  );

  // No grant is shown while held in reset.
  assign gnt     = pick & {NREQ{reset}};
  assign xfer    = |gnt;
  assign bus.gnt = gnt;

  always_comb begin
    win   = '0;
    w_sel = 1'b0;
    a_sel = '0;
    d_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win   = IW'(i);
        w_sel = bus.we[i];
        a_sel = bus.addr[i*AW +: AW];
        d_sel = bus.wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    last_d    = xfer ? win : last_q;
    addr_d    = xfer ? a_sel : addr_q;
    do_d      = xfer ? d_sel : do_q;
    wr_d      = xfer & w_sel;
    rd_d      = xfer & ~w_sel;
    pipe_d[0] = '{valid: rd_d, id: RES_IDW'(win)};
    pipe_d[1] = pipe_q[0];
    rvalid_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rvalid_d[i] = pipe_q[1].valid && (pipe_q[1].id == RES_IDW'(i));
    end
    rdata_d = pipe_q[1].valid ? res_di : rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q   <= IW'(NREQ - 1);
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      do_q     <= '0;
      pipe_q   <= '{default: '0};
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      last_q   <= last_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      do_q     <= do_d;
      pipe_q   <= pipe_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign res_rd     = rd_q;
  assign res_wr     = wr_q;
  assign res_addr   = addr_q;
  assign res_do     = do_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_res_ram_arbiter.sv
// Bench for res_ram_arbiter with a behavioural result RAM.
// Lock sequence runs when RES_ARB_LOCK_EN is defined.
module tb_res_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        res_rd;
  logic        res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [7:0]  res_di;
  logic [7:0]  rd_pend;
  logic [7:0]  mem [16384];

  int checks;
  int errors;

  res_ram_arbiter_if #(.NREQ(2), .AW(14), .DW(8)) bus ();

  res_ram_arbiter #(.NREQ(2), .AW(14), .DW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .res_rd   (res_rd),
    .res_wr   (res_wr),
    .res_addr (res_addr),
    .res_do   (res_do),
    .res_di   (res_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: writes on rising edge; read address sampled on falling edge,
  // data presented on the following falling edge.
  always @(posedge clk) begin
    if (res_wr) mem[res_addr] <= res_do;
  end

  always @(negedge clk) begin
    res_di <= rd_pend;
    if (res_rd) rd_pend <= mem[res_addr];
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [13:0] a0;
    logic [13:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [7:0]  rd;
    logic [1:0]  rw;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [13:0] a0, input logic [13:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    bus.req   = req;
    bus.we    = we;
    bus.addr  = {a1, a0};
    bus.wdata = {d1, d0};
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    res_di  = '0;
    rd_pend = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[14'h3FFF] = 8'h00;

    tv[0]  = '{2'b01, 2'b01, 14'h3FFF, 14'h0, 8'hA5, 8'h0, 2'b01, 2'b00, 8'h00, 2'b00};
    tv[1]  = '{2'b01, 2'b00, 14'h3FFF, 14'h0, 8'h00, 8'h0, 2'b01, 2'b00, 8'h00, 2'b01};
    tv[2]  = '{2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 2'b00, 2'b00, 8'h00, 2'b10};
    tv[3]  = '{2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 2'b00, 2'b00, 8'h00, 2'b00};
    tv[4]  = '{2'b11, 2'b00, 14'h0020, 14'h0031, 8'h0, 8'h0, 2'b10, 2'b01, 8'hA5, 2'b00};
    tv[5]  = '{2'b11, 2'b00, 14'h0020, 14'h0031, 8'h0, 8'h0, 2'b01, 2'b00, 8'h00, 2'b10};
    tv[6]  = '{2'b11, 2'b00, 14'h0020, 14'h0031, 8'h0, 8'h0, 2'b10, 2'b00, 8'h00, 2'b10};
    tv[7]  = '{2'b11, 2'b00, 14'h0020, 14'h0031, 8'h0, 8'h0, 2'b01, 2'b10, 8'h6B, 2'b10};
    tv[8]  = '{2'b11, 2'b00, 14'h0020, 14'h0031, 8'h0, 8'h0, 2'b10, 2'b01, 8'h7A, 2'b10};
    tv[9]  = '{2'b11, 2'b00, 14'h0020, 14'h0031, 8'h0, 8'h0, 2'b01, 2'b10, 8'h6B, 2'b10};
    tv[10] = '{2'b11, 2'b00, 14'h0020, 14'h0031, 8'h0, 8'h0, 2'b10, 2'b01, 8'h7A, 2'b10};
    tv[11] = '{2'b11, 2'b00, 14'h0020, 14'h0031, 8'h0, 8'h0, 2'b01, 2'b10, 8'h6B, 2'b10};
    tv[12] = '{2'b10, 2'b10, 14'h0, 14'h0010, 8'h0, 8'h07, 2'b10, 2'b01, 8'h7A, 2'b10};
    tv[13] = '{2'b01, 2'b00, 14'h0010, 14'h0, 8'h0, 8'h0, 2'b01, 2'b10, 8'h6B, 2'b01};
    tv[14] = '{2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 2'b00, 2'b01, 8'h7A, 2'b10};
    tv[15] = '{2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 2'b00, 2'b00, 8'h00, 2'b00};
    tv[16] = '{2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 2'b00, 2'b01, 8'h07, 2'b00};
    tv[17] = '{2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0, 2'b00, 2'b00, 8'h00, 2'b00};

    // Reset held with both requesting
    reset = 1'b0;
    drive(2'b11, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
`ifdef RES_ARB_LOCK_EN
    bus.lock = 2'b00;
`endif
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_rdwr", 32'({res_rd, res_wr}), 32'h0);
      chk("rst_addr", 32'(res_addr), 32'h0);
      chk("rst_do", 32'(res_do), 32'h0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
      chk("rst_rdata", 32'(bus.rdata), 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("first_gnt", 32'(bus.gnt), 32'h1);
    drive(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1 drive(tv[i].req, tv[i].we, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(tv[i].gnt));
      chk($sformatf("v%0d_rvalid", i), 32'(bus.rvalid), 32'(tv[i].rv));
      chk($sformatf("v%0d_rdwr", i), 32'({res_rd, res_wr}), 32'(tv[i].rw));
      if (tv[i].rv != 2'b00)
        chk($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(tv[i].rd));
      if (i == 1) begin
        chk("wr_addr", 32'(res_addr), 32'h3FFF);
        chk("wr_data", 32'(res_do), 32'hA5);
      end
    end

    // Reset while a read is in flight
    @(posedge clk);
    #1 drive(2'b01, 2'b00, 14'h0020, 14'h0, 8'h0, 8'h0);
    @(posedge clk);
    #1 drive(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midrst_rd", 32'(res_rd), 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_rv_low", 32'(bus.rvalid), 32'h0);
      chk("midrst_rdwr_low", 32'({res_rd, res_wr}), 32'h0);
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_rv", 32'(bus.rvalid), 32'h0);
      chk("midrst_rdata", 32'(bus.rdata), 32'h0);
    end

`ifdef RES_ARB_LOCK_EN
    // Requester 1 (last after reset) holds lock
    repeat (5) begin
      @(posedge clk);
      #1 drive(2'b11, 2'b11, 14'h1, 14'h2, 8'h1, 8'h2);
      bus.lock = 2'b10;
      @(negedge clk);
      chk("lock_gnt", 32'(bus.gnt), 32'h2);
    end
    @(posedge clk);
    #1 bus.lock = 2'b00;
    @(negedge clk);
    chk("unlock_gnt", 32'(bus.gnt), 32'h1);
    drive(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/res_ram_arbiter.md
# res_ram_arbiter

Round-robin arbiter that shares the single-port result RAM (14-bit address, 8-bit data, 16384 entries) among NREQ requesters, e.g. the sti loader, the forward-pass engine, the backward-pass engine and a debug readback port. It sits between those engines and the RAM pins `res_rd`/`res_wr`/`res_addr`/`res_do`/`res_di`. The RAM samples reads on the falling edge and writes on the rising edge. The arbiter registers all RAM-side outputs and returns read data to the winning requester with a fixed latency.

## Interface
- NREQ, 2: number of requesters (2..8)
- AW, 14: RAM address width
- DW, 8: RAM data width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester access request; held until granted
- we  in  NREQ  per-requester write (1) / read (0) select
- addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
- lock  in  NREQ  burst lock (present only with RES_ARB_LOCK_EN)
- gnt  out  NREQ  one-hot combinational grant; transfer = req[i] & gnt[i] at rising edge
- rvalid  out  NREQ  one-hot registered read-return strobe, one cycle
- rdata  out  DW  read data, valid while any rvalid bit is high
- res_rd  out  1  RAM read enable (registered)
- res_wr  out  1  RAM write enable (registered)
- res_addr  out  AW  RAM address (registered)
- res_do  out  DW  RAM write data (registered)
- res_di  in  DW  RAM read data (changes on falling edge)

## Operation
- Arbitration: pointer `last` (index of most recent transfer). The highest priority goes to `last+1`, then the next indices in ascending order, modulo NREQ. `gnt` is one-hot or zero and depends only on `req` and `last` (plus `lock`).
- On each rising edge with a transfer by requester k:
  - `last <= k`
  - `res_addr <= addr[k]`
  - `res_do <= wdata[k]`
  - `res_wr <= we[k]`
  - `res_rd <= ~we[k]`
- No transfer: `res_rd = res_wr = 0`. `res_addr` and `res_do` hold their previous values.
- Read return: a two-entry shift pipeline of {valid, id}. A read transfer at edge T raises `rvalid[k]` after edge T+2, with `rdata` = `res_di` sampled at edge T+2.
- Back-to-back reads from any mix of requesters return in transfer order, one per cycle.
- Requester obligations:
  - Keep `req`, `we`, `addr` and `wdata` stable until the grant cycle.
  - After the grant it may drop `req` or present the next access in the following cycle.
- One access per cycle is accepted in total. The arbiter can sustain 100% RAM utilisation.

## Timing
- Reset values:
  - `res_rd`, `res_wr`, `res_addr`, `res_do`, `rvalid`, `rdata`: 0
  - `last`: NREQ-1, so requester 0 has first priority
  - read pipeline: cleared
- Write latency: transfer at edge T; RAM writes at edge T+1.
- Read latency: transfer at edge T; `rvalid` and `rdata` are visible during cycle T+2..T+3.
- Reset mid-operation: in-flight reads are discarded with no `rvalid`. No RAM access occurs while reset is low.
- Single requester: it is granted every cycle it requests.
- All requesters continuous: grants rotate 0,1,…,NREQ-1,0.
- A read and a write to the same address in consecutive transfers: the write is issued first at edge T and lands in the RAM at edge T+1. The following read is issued at edge T+1 and samples the RAM on the falling edge after T+1, so it returns the new data.

## Configuration
- `RES_ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - If `lock[last]` and `req[last]` are both high, only `last` is eligible, so it keeps the grant every cycle until lock drops.
  - Lock by a requester that is not `last` has no effect.
- `RES_ARB_LOCK_EN` undefined: no `lock` port; pure round-robin.

## Structure
- `res_arb_pkg`:
  - constants `RES_AW = 14`, `RES_DW = 8`, `RES_DEPTH = 16384`
  - typedef for the read-pipeline entry {valid, id}
- Sub-module `rr_pick`: combinational one-hot round-robin picker (inputs: request vector and `last`; output: grant vector). It is instantiated once.
- Top level: lock masking, output registers, read-return pipeline.

## Test plan
- Reset: drive `reset = 0` for 3 cycles with `req = 2'b11` -> all outputs 0 and no RAM access. Then release reset -> the first grant goes to requester 0.
- Single write then read: requester 0 writes 0xA5 to address 0x3FFF, then reads 0x3FFF -> `rvalid[0]` two cycles after the read grant, with `rdata = 0xA5`.
- Fairness: `req = 2'b11`, all reads, for 8 cycles -> `gnt` alternates 01,10,… and `rvalid` alternates in the same order with matching data.
- Back-to-back same-address write then read (requester 1 writes 0x07 to 0x0010; requester 0 then reads 0x0010) -> the read returns 0x07.
- Reset mid-read: read granted, then `reset` low before `rvalid` -> no `rvalid` after release, and `rdata = 0`.
- Lock (RES_ARB_LOCK_EN): requester 1 holds `lock` and `req` for 5 cycles while `req[0] = 1` -> 5 consecutive grants to 1, then requester 0 is granted in the cycle after lock drops.
